axis_detector_player: RTL
=========================

Name: axis_detector_player

Overview:
- Replays timestamped detector hit patterns onto a 64-bit detector bus (4 channels x 16 bits).
- Consumes 128-bit AXI4-Stream events, tdata = {time[63:0], pattern[63:0]}.
- At the requested time, drives the pattern for a programmable number of cycles, then returns the bus to zero.
- Feeds the detector-bus input of the coincidence reader for loopback calibration and emulation without real detectors; event format matches the reader's output.

Parameters:
- none; widths are fixed: 64-bit time, 64-bit pattern, 4-bit pulse length.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- cfg_data  in  4  pulse length minus one; pulse lasts cfg_data+1 cycles
- s_axis_tdata  in  128  [127:64] event time, [63:0] hit pattern
- s_axis_tvalid  in  1  event valid
- s_axis_tready  out  1  event accepted when tvalid & tready
- det_data  out  64  emulated detector bus, registered
- sts_time  out  64  free-running time counter
- sts_late  out  32  count of late events, saturating
- sts_busy  out  1  high when state != IDLE

Behaviour:
- Reset: aresetn is synchronous, active-low; clock is aclk.
  - While aresetn is low: state=IDLE, det_data=0, time=0, sts_late=0, pulse counter=0, latched event=0, sts_busy=0.
  - s_axis_tready = (state==IDLE) & aresetn, so tready is 0 during reset.
- Time counter:
  - 64-bit, increments by 1 every cycle out of reset.
  - sts_time is the register value; it reads 0 in the first cycle after release.
  - Wrap-around is natural modulo 2^64 with no special handling.
- Reset mid-operation: any pending or firing event is discarded; det_data reads 0 after the reset edge.
- FSM, IDLE (0):
  - tready=1.
  - On tvalid&tready: latch evt_time=tdata[127:64] and evt_pat=tdata[63:0], go to WAIT.
- FSM, WAIT (1):
  - tready=0.
  - When sts_time >= evt_time (unsigned):
    - det_data<=evt_pat; latch pw=cfg_data; cntr<=0; go to FIRE.
    - If sts_time > evt_time (strictly late), sts_late<=sts_late+1, saturating at 0xFFFFFFFF.
  - Equality is on time, not late.
  - Otherwise stay in WAIT.
- FSM, FIRE (2):
  - cntr increments each cycle.
  - When cntr==pw: det_data<=0, go to IDLE.
- Timing:
  - Let s be the sts_time value of the WAIT cycle in which the compare succeeds (s = evt_time for on-time events).
  - det_data == evt_pat exactly while sts_time is in [s+1, s+pw+1]; it is 0 at all other times.
  - Pattern is driven unmasked; bits 0 and 15 of each channel are passed through as given.
- Throughput:
  - Event accepted at sts_time=a gives earliest fire s=a+1.
  - After a pulse ends, the next pulse starts no earlier than 2 zero cycles later (IDLE + WAIT), which guarantees a falling edge for the downstream trigger.
  - tdata is ignored outside the handshake.
- cfg_data may change at any time; only the value latched at WAIT->FIRE affects the current pulse.
- Zero pattern: processed normally (timing, late count); det_data stays 0.
- No combinational path from s_axis_tvalid to any output.
- States 3..7 are unreachable; if ever entered, the next state is IDLE.

Test Plan:
- Reset:
  - Stimulus: aresetn low 4 cycles with tvalid=1.
  - Response: tready=0, det_data=0, sts_late=0; sts_time=0 in the first cycle after release, then 1, 2, 3.
- On-time event:
  - Stimulus: cfg_data=3; send {time=100, pat=0x0001_0000_0000_8000} at sts_time=10.
  - Response: det_data=pattern for sts_time 101..104; 0 at 100 and 105; sts_late=0; tready low 11..104, high at 105.
- Late event:
  - Stimulus: cfg_data=0; at sts_time=50 send {time=20, pat=0xFFFF}.
  - Response: fire at s=51; det_data=0xFFFF only at sts_time 52; sts_late=1.
- Back-to-back:
  - Stimulus: tvalid held high with events {200,A} then {200,B}; cfg_data=1.
  - Response: A at 201..202; 0 at 203 and 204; B at 205..206; sts_late=1.
- cfg change and reset:
  - cfg change: change cfg_data 3->7 during FIRE; the current pulse stays 4 cycles.
  - Reset: assert aresetn during WAIT of an event at time 1000; nothing is driven after release.
- Saturation:
  - Stimulus: force sts_late to 0xFFFFFFFE, send 3 late events.
  - Response: reads 0xFFFFFFFF and holds.

Source files
------------

// File: rtl/axis_detector_player_if.sv
// AXI4-Stream event channel for the detector player: 128-bit {time, pattern} beats.
interface axis_detector_player_if;
   logic [127:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_detector_player.sv
// Replays timestamped hit patterns onto a 64-bit detector bus; one event is
// accepted, waited for, and then driven for cfg_data+1 cycles before returning to zero.
module axis_detector_player (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [3:0]                   cfg_data,
   axis_detector_player_if.slave        s_axis,
   output logic [63:0]                  det_data,
   output logic [63:0]                  sts_time,
   output logic [31:0]                  sts_late,
   output logic                         sts_busy
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_FIRE = 3'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [63:0] time_q;
   logic [63:0] evt_time;
   logic [63:0] evt_pat;
   logic [31:0] late_q;
   logic [3:0]  pw;
   logic [3:0]  cntr;
   logic        accept;
   logic        due;
   logic        pulse_done;

   assign accept     = s_axis.tvalid && s_axis.tready;
   assign due        = (time_q >= evt_time);
   assign pulse_done = (cntr == pw);

   // tready depends only on registered state and reset, never on tvalid.
   assign s_axis.tready = (state == S_IDLE) && aresetn;
   assign sts_time      = time_q;
   assign sts_late      = late_q;
   assign sts_busy      = (state != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge aclk) begin
      if (!aresetn) state <= S_IDLE;
      else          state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = S_IDLE;
      case (state)
         S_IDLE:  state_next = accept     ? S_WAIT : S_IDLE;
         S_WAIT:  state_next = due        ? S_FIRE : S_WAIT;
         S_FIRE:  state_next = pulse_done ? S_IDLE : S_FIRE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         time_q   <= '0;
         evt_time <= '0;
         evt_pat  <= '0;
         late_q   <= '0;
         pw       <= '0;
         cntr     <= '0;
         det_data <= '0;
      end else begin
         time_q <= time_q + 64'd1;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  evt_time <= s_axis.tdata[127:64];
                  evt_pat  <= s_axis.tdata[63:0];
               end
            end
            S_WAIT: begin
               if (due) begin
                  det_data <= evt_pat;
                  pw       <= cfg_data;
                  cntr     <= '0;
                  // Equality means on time; only strictly later counts as late.
                  if (time_q != evt_time && late_q != '1)
                     late_q <= late_q + 32'd1;
               end
            end
            S_FIRE: begin
               cntr <= cntr + 4'd1;
               if (pulse_done) det_data <= '0;
            end
            default: det_data <= '0;
         endcase
      end
   end

endmodule
